// File: rtl/coproc_custom0_issuer.sv
// custom0 coprocessor initiator: issues operand pairs on the genfifo req stream,
// tracks destination tags in order and hands responses to register writeback.

package coproc_custom0_issuer_pkg;

   typedef struct packed {
      logic [31:0] src0_data;
      logic [31:0] src1_data;
   } req_struct;

   typedef struct packed {
      logic [31:0] result;
   } resp_struct;

endpackage

module coproc_custom0_issuer
   import coproc_custom0_issuer_pkg::*;
#(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        cmd_req_i,
   input  logic [31:0] cmd_src0_i,
   input  logic [31:0] cmd_src1_i,
   input  logic [4:0]  cmd_rd_i,
   output logic        cmd_ack_o,

   output logic        stream_req_bus_genfifo_req_o,
   output req_struct   stream_req_bus_genfifo_wdata_bo,
   input  logic        stream_req_bus_genfifo_ack_i,

   input  logic        stream_resp_bus_genfifo_req_i,
   input  resp_struct  stream_resp_bus_genfifo_rdata_bi,
   output logic        stream_resp_bus_genfifo_ack_o,

   output logic        wb_req_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_wdata_o,
   input  logic        wb_ack_i,

   output logic        busy_o,
   output logic        err_o,
   input  logic        err_clr_i
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TAG_W = 5;

   // registered state
   logic              req_valid_q;
   req_struct         req_data_q;
   logic [TAG_W-1:0]  tag_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [TMR_W-1:0]  timer_q;
   logic              wb_valid_q;
   logic [TAG_W-1:0]  wb_rd_q;
   logic [31:0]       wb_data_q;
   logic              err_q;
   logic              busy_q;

   // next-state
   logic              req_valid_n;
   req_struct         req_data_n;
   logic [PTR_W-1:0]  wr_ptr_n;
   logic [PTR_W-1:0]  rd_ptr_n;
   logic [CNT_W-1:0]  count_n;
   logic [TMR_W-1:0]  timer_n;
   logic              wb_valid_n;
   logic [TAG_W-1:0]  wb_rd_n;
   logic [31:0]       wb_data_n;
   logic              err_n;
   logic              busy_n;

   logic              cmd_accept;
   logic              resp_xfer;
   logic              fifo_empty;
   logic              pop;
   logic              spurious;
   logic              timeout_hit;
   logic [TAG_W-1:0]  head_tag;

   always_comb begin
      req_valid_n = req_valid_q;
      req_data_n  = req_data_q;
      wr_ptr_n    = wr_ptr_q;
      rd_ptr_n    = rd_ptr_q;
      count_n     = count_q;
      timer_n     = timer_q;
      wb_valid_n  = wb_valid_q;
      wb_rd_n     = wb_rd_q;
      wb_data_n   = wb_data_q;
      err_n       = err_q;

      fifo_empty  = (count_q == CNT_W'(0));
      cmd_accept  = cmd_req_i && !req_valid_q && (count_q < CNT_W'(DEPTH)) && !err_q;
      resp_xfer   = stream_resp_bus_genfifo_req_i && (!wb_valid_q || wb_ack_i);
      pop         = resp_xfer && !fifo_empty;
      spurious    = resp_xfer && fifo_empty;
      head_tag    = tag_mem[rd_ptr_q];
      timeout_hit = !resp_xfer && !fifo_empty && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

      // request slot
      if (req_valid_q && stream_req_bus_genfifo_ack_i) begin
         req_valid_n = 1'b0;
      end
      if (cmd_accept) begin
         req_valid_n          = 1'b1;
         req_data_n.src0_data = cmd_src0_i;
         req_data_n.src1_data = cmd_src1_i;
      end

      // tag FIFO pointers and occupancy; pointers wrap since DEPTH is a power of 2
      if (cmd_accept) begin
         wr_ptr_n = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_n = rd_ptr_q + PTR_W'(1);
      end
      if (cmd_accept && !pop) begin
         count_n = count_q + CNT_W'(1);
      end else if (!cmd_accept && pop) begin
         count_n = count_q - CNT_W'(1);
      end

      // writeback slot; rd==0 results are dropped
      if (wb_valid_q && wb_ack_i) begin
         wb_valid_n = 1'b0;
      end
      if (pop && (head_tag != TAG_W'(0))) begin
         wb_valid_n = 1'b1;
         wb_rd_n    = head_tag;
         wb_data_n  = stream_resp_bus_genfifo_rdata_bi.result;
      end

      // response watchdog
      if (resp_xfer || fifo_empty || timeout_hit) begin
         timer_n = TMR_W'(0);
      end else begin
         timer_n = timer_q + TMR_W'(1);
      end

      // a timeout abandons everything in flight
      if (timeout_hit) begin
         req_valid_n = 1'b0;
         wr_ptr_n    = PTR_W'(0);
         rd_ptr_n    = PTR_W'(0);
         count_n     = CNT_W'(0);
      end

      // set dominates clear
      if (spurious || timeout_hit) begin
         err_n = 1'b1;
      end else if (err_clr_i) begin
         err_n = 1'b0;
      end

      busy_n = (count_n != CNT_W'(0)) || req_valid_n || wb_valid_n;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         req_valid_q <= 1'b0;
         req_data_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         timer_q     <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         req_valid_q <= req_valid_n;
         req_data_q  <= req_data_n;
         wr_ptr_q    <= wr_ptr_n;
         rd_ptr_q    <= rd_ptr_n;
         count_q     <= count_n;
         timer_q     <= timer_n;
         wb_valid_q  <= wb_valid_n;
         wb_rd_q     <= wb_rd_n;
         wb_data_q   <= wb_data_n;
         err_q       <= err_n;
         busy_q      <= busy_n;
      end
   end

   // tag storage; contents are don't-care while the FIFO is empty
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_mem[i] <= '0;
         end
      end else if (cmd_accept) begin
         tag_mem[wr_ptr_q] <= cmd_rd_i;
      end
   end

   assign cmd_ack_o                       = cmd_accept;
   assign stream_resp_bus_genfifo_ack_o   = resp_xfer;
   assign stream_req_bus_genfifo_req_o    = req_valid_q;
   assign stream_req_bus_genfifo_wdata_bo = req_data_q;
   assign wb_req_o                        = wb_valid_q;
   assign wb_rd_o                         = wb_rd_q;
   assign wb_wdata_o                      = wb_data_q;
   assign busy_o                          = busy_q;
   assign err_o                           = err_q;

endmodule

// File: tb/tb_coproc_custom0_issuer.sv
// Directed bench for coproc_custom0_issuer (DEPTH=4, TIMEOUT_CYCLES=16).

module tb_coproc_custom0_issuer;
   import coproc_custom0_issuer_pkg::*;

   logic        clk;
   logic        rst_i;
   logic        cmd_req_i;
   logic [31:0] cmd_src0_i;
   logic [31:0] cmd_src1_i;
   logic [4:0]  cmd_rd_i;
   logic        cmd_ack_o;
   logic        req_o;
   req_struct   wdata;
   logic        req_ack_i;
   logic        resp_req_i;
   resp_struct  rdata;
   logic        resp_ack_o;
   logic        wb_req_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_wdata_o;
   logic        wb_ack_i;
   logic        busy_o;
   logic        err_o;
   logic        err_clr_i;

   int n_checks = 0;
   int n_pass   = 0;

   coproc_custom0_issuer #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk_i                            (clk),
      .rst_i                            (rst_i),
      .cmd_req_i                        (cmd_req_i),
      .cmd_src0_i                       (cmd_src0_i),
      .cmd_src1_i                       (cmd_src1_i),
      .cmd_rd_i                         (cmd_rd_i),
      .cmd_ack_o                        (cmd_ack_o),
      .stream_req_bus_genfifo_req_o     (req_o),
      .stream_req_bus_genfifo_wdata_bo  (wdata),
      .stream_req_bus_genfifo_ack_i     (req_ack_i),
      .stream_resp_bus_genfifo_req_i    (resp_req_i),
      .stream_resp_bus_genfifo_rdata_bi (rdata),
      .stream_resp_bus_genfifo_ack_o    (resp_ack_o),
      .wb_req_o                         (wb_req_o),
      .wb_rd_o                          (wb_rd_o),
      .wb_wdata_o                       (wb_wdata_o),
      .wb_ack_i                         (wb_ack_i),
      .busy_o                           (busy_o),
      .err_o                            (err_o),
      .err_clr_i                        (err_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
      check({tag, "_wb_req"}, 64'(wb_req_o), 64'd1);
      check({tag, "_wb_rd"}, 64'(wb_rd_o), 64'(rd));
      check({tag, "_wb_data"}, 64'(wb_wdata_o), 64'(data));
   endtask

   initial begin
      rst_i      = 1'b0;
      cmd_req_i  = 1'b0;
      cmd_src0_i = '0;
      cmd_src1_i = '0;
      cmd_rd_i   = '0;
      req_ack_i  = 1'b0;
      resp_req_i = 1'b0;
      rdata      = '0;
      wb_ack_i   = 1'b0;
      err_clr_i  = 1'b0;

      // reset state
      tick(); tick();
      #1;
      check("rst_req", 64'(req_o), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      check("rst_wb_req", 64'(wb_req_o), 64'd0);
      check("rst_wb_data", 64'(wb_wdata_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      rst_i = 1'b1;
      tick();

      // single op, immediate request ack
      cmd_req_i = 1'b1; cmd_src0_i = 32'h12345678; cmd_src1_i = 32'h0; cmd_rd_i = 5'd5;
      req_ack_i = 1'b1;
      #1 check("t1_cmd_ack", 64'(cmd_ack_o), 64'd1);
      tick(); cmd_req_i = 1'b0;
      #1;
      check("t1_req", 64'(req_o), 64'd1);
      check("t1_payload", 64'(wdata), 64'h12345678_00000000);
      tick(); req_ack_i = 1'b0;
      #1 check("t1_req_clr", 64'(req_o), 64'd0);
      tick();
      resp_req_i = 1'b1; rdata.result = 32'hDEADBEEF;
      #1 check("t1_resp_ack", 64'(resp_ack_o), 64'd1);
      tick(); resp_req_i = 1'b0;
      #1;
      check_wb("t1", 5'd5, 32'hDEADBEEF);
      check("t1_busy", 64'(busy_o), 64'd1);
      wb_ack_i = 1'b1;
      tick(); wb_ack_i = 1'b0;
      #1;
      check("t1_wb_done", 64'(wb_req_o), 64'd0);
      check("t1_idle", 64'(busy_o), 64'd0);

      // request back-pressure
      cmd_req_i = 1'b1; cmd_src0_i = 32'hA1A1A1A1; cmd_src1_i = 32'hB1B1B1B1; cmd_rd_i = 5'd7;
      tick();
      cmd_src0_i = 32'hA2A2A2A2; cmd_src1_i = 32'hB2B2B2B2; cmd_rd_i = 5'd8;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t2_req_hold", 64'(req_o), 64'd1);
         check("t2_payload_hold", 64'(wdata), 64'hA1A1A1A1_B1B1B1B1);
         check("t2_cmd_blocked", 64'(cmd_ack_o), 64'd0);
         tick();
      end
      req_ack_i = 1'b1;
      #1 check("t2_slot_busy_on_ack", 64'(cmd_ack_o), 64'd0);
      tick(); req_ack_i = 1'b0;
      #1;
      check("t2_req_clr", 64'(req_o), 64'd0);
      check("t2_cmd2_ack", 64'(cmd_ack_o), 64'd1);
      tick(); cmd_req_i = 1'b0;
      #1;
      check("t2_req2", 64'(req_o), 64'd1);
      check("t2_payload2", 64'(wdata), 64'hA2A2A2A2_B2B2B2B2);
      req_ack_i = 1'b1;
      tick(); req_ack_i = 1'b0;

      // writeback back-pressure
      resp_req_i = 1'b1; rdata.result = 32'h111;
      #1 check("t2_resp1_ack", 64'(resp_ack_o), 64'd1);
      tick();
      rdata.result = 32'h222;
      #1 check("t2_resp2_stall", 64'(resp_ack_o), 64'd0);
      tick();
      #1;
      check_wb("t2_hold", 5'd7, 32'h111);
      check("t2_resp2_still_stall", 64'(resp_ack_o), 64'd0);
      wb_ack_i = 1'b1;
      #1 check("t2_resp2_ack", 64'(resp_ack_o), 64'd1);
      tick(); resp_req_i = 1'b0; wb_ack_i = 1'b0;
      #1 check_wb("t2_second", 5'd8, 32'h222);
      wb_ack_i = 1'b1;
      tick(); wb_ack_i = 1'b0;
      #1 check("t2_idle", 64'(busy_o), 64'd0);

      // fill the tag FIFO
      req_ack_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cmd_req_i = 1'b1; cmd_rd_i = 5'(i); cmd_src0_i = 32'(i); cmd_src1_i = 32'h0;
         tick(); cmd_req_i = 1'b0;
         tick();
      end
      cmd_req_i = 1'b1; cmd_rd_i = 5'd9; cmd_src0_i = 32'h9;
      #1 check("t3_full_block", 64'(cmd_ack_o), 64'd0);
      tick();
      #1 check("t3_full_block2", 64'(cmd_ack_o), 64'd0);
      cmd_req_i = 1'b0;
      wb_ack_i = 1'b1;
      resp_req_i = 1'b1; rdata.result = 32'hA;
      tick();
      #1 check_wb("t3_a", 5'd1, 32'hA);
      rdata.result = 32'hB; cmd_req_i = 1'b1;
      #1 check("t3_push_pop_ack", 64'(cmd_ack_o), 64'd1);
      tick(); cmd_req_i = 1'b0;
      #1 check_wb("t3_b", 5'd2, 32'hB);
      rdata.result = 32'hC;
      tick();
      #1 check_wb("t3_c", 5'd3, 32'hC);
      rdata.result = 32'hD;
      tick();
      #1 check_wb("t3_d", 5'd4, 32'hD);
      rdata.result = 32'hE;
      tick();
      #1 check_wb("t3_e", 5'd9, 32'hE);
      resp_req_i = 1'b0;
      tick(); wb_ack_i = 1'b0;
      #1;
      check("t3_wb_done", 64'(wb_req_o), 64'd0);
      check("t3_idle", 64'(busy_o), 64'd0);
      check("t3_no_err", 64'(err_o), 64'd0);

      // rd==0 result is acked and dropped
      cmd_req_i = 1'b1; cmd_rd_i = 5'd0;
      tick(); cmd_req_i = 1'b0;
      tick(); req_ack_i = 1'b0;
      #1 check("t4_busy", 64'(busy_o), 64'd1);
      resp_req_i = 1'b1; rdata.result = 32'h55;
      #1 check("t4_resp_ack", 64'(resp_ack_o), 64'd1);
      tick(); resp_req_i = 1'b0;
      #1;
      check("t4_no_wb", 64'(wb_req_o), 64'd0);
      check("t4_idle", 64'(busy_o), 64'd0);
      check("t4_no_err", 64'(err_o), 64'd0);

      // spurious response
      resp_req_i = 1'b1; rdata.result = 32'h99;
      #1 check("t5_resp_ack", 64'(resp_ack_o), 64'd1);
      tick(); resp_req_i = 1'b0;
      #1;
      check("t5_err", 64'(err_o), 64'd1);
      check("t5_no_wb", 64'(wb_req_o), 64'd0);
      cmd_req_i = 1'b1; cmd_rd_i = 5'd3;
      #1 check("t5_cmd_blocked", 64'(cmd_ack_o), 64'd0);
      cmd_req_i = 1'b0; err_clr_i = 1'b1;
      tick(); err_clr_i = 1'b0;
      #1 check("t5_err_clr", 64'(err_o), 64'd0);
      resp_req_i = 1'b1; err_clr_i = 1'b1;
      tick(); resp_req_i = 1'b0; err_clr_i = 1'b0;
      #1 check("t5_set_wins", 64'(err_o), 64'd1);
      err_clr_i = 1'b1;
      tick(); err_clr_i = 1'b0;
      #1 check("t5_err_clr2", 64'(err_o), 64'd0);

      // timeout with request slot stalled
      cmd_req_i = 1'b1; cmd_rd_i = 5'd6; cmd_src0_i = 32'h66;
      tick(); cmd_req_i = 1'b0;
      repeat (15) tick();
      #1;
      check("t6_err_early", 64'(err_o), 64'd0);
      check("t6_busy_early", 64'(busy_o), 64'd1);
      tick();
      #1;
      check("t6_err", 64'(err_o), 64'd1);
      check("t6_flushed_busy", 64'(busy_o), 64'd0);
      check("t6_flushed_req", 64'(req_o), 64'd0);
      err_clr_i = 1'b1;
      tick(); err_clr_i = 1'b0;
      resp_req_i = 1'b1; rdata.result = 32'h77;
      tick(); resp_req_i = 1'b0;
      #1;
      check("t6_fifo_empty", 64'(err_o), 64'd1);
      check("t6_no_wb", 64'(wb_req_o), 64'd0);
      err_clr_i = 1'b1;
      tick(); err_clr_i = 1'b0;

      // reset mid-flight
      cmd_req_i = 1'b1; cmd_rd_i = 5'd10; cmd_src0_i = 32'hCAFE; cmd_src1_i = 32'hF00D;
      tick(); cmd_req_i = 1'b0;
      #1 check("t7_req_before", 64'(req_o), 64'd1);
      rst_i = 1'b0;
      tick(); rst_i = 1'b1;
      #1;
      check("t7_req_rst", 64'(req_o), 64'd0);
      check("t7_wdata_rst", 64'(wdata), 64'd0);
      check("t7_busy_rst", 64'(busy_o), 64'd0);
      resp_req_i = 1'b1; rdata.result = 32'h88;
      tick(); resp_req_i = 1'b0;
      #1;
      check("t7_late_resp_err", 64'(err_o), 64'd1);
      check("t7_late_resp_no_wb", 64'(wb_req_o), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/coproc_custom0_issuer.md
Name: coproc_custom0_issuer

Overview:
- CPU-side initiator for the custom0 coprocessor genfifo protocol.
- Accepts custom0 commands (src0, src1, destination register) from the pipeline and issues them on the req stream.
- Tracks outstanding destinations in order, receives results on the resp stream, and presents them to register-file writeback.
- Detects spurious responses and response timeouts.

Parameters:
- DEPTH, 4: max outstanding requests (tag FIFO depth), power of 2, ≥2.
- TIMEOUT_CYCLES, 1024: cycles without a response while requests are outstanding before err_o is raised; ≥2.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-low
- cmd_req_i  input  1  pipeline command valid
- cmd_src0_i  input  32  operand 0
- cmd_src1_i  input  32  operand 1
- cmd_rd_i  input  5  destination register
- cmd_ack_o  output  1  command accepted this cycle
- stream_req_bus_genfifo_req_o  output  1  request valid to coprocessor
- stream_req_bus_genfifo_wdata_bo  output  req_struct  request payload (src0_data, src1_data)
- stream_req_bus_genfifo_ack_i  input  1  coprocessor accepted request
- stream_resp_bus_genfifo_req_i  input  1  response valid from coprocessor
- stream_resp_bus_genfifo_rdata_bi  input  resp_struct  32-bit result
- stream_resp_bus_genfifo_ack_o  output  1  response consumed
- wb_req_o  output  1  writeback valid
- wb_rd_o  output  5  writeback register
- wb_wdata_o  output  32  writeback data
- wb_ack_i  input  1  writeback accepted
- busy_o  output  1  outstanding count ≠ 0 or request slot full
- err_o  output  1  sticky error
- err_clr_i  input  1  clears err_o

Behaviour:
- Reset (rst_i==0 at a clock edge): all outputs 0, payload registers 0, tag FIFO empty, timeout counter 0. Reset mid-transaction drops all in-flight state; responses arriving after reset are spurious.
- Handshakes: a transfer occurs on any interface in a cycle where req and ack are both high. A valid, once raised, holds with a stable payload until acked.
- Command accept:
  - cmd_ack_o = cmd_req_i && request slot empty && fifo_count < DEPTH && !err_o. Combinational.
  - No same-cycle bypass on a full FIFO.
  - On accept: load src0/src1 into the request slot and push cmd_rd_i into the tag FIFO.
- Request issue: stream_req_bus_genfifo_req_o rises the cycle after accept. It clears on the ack cycle; the slot is reusable the following cycle (one request per 2 cycles max).
- Response:
  - stream_resp_bus_genfifo_ack_o = resp_req_i && (wb slot empty || wb_ack_i). Combinational.
  - On transfer with a non-empty FIFO: pop the tag.
    - If tag ≠ 0, load the wb slot; wb_req_o, wb_rd_o and wb_wdata_o are valid the next cycle.
    - If tag == 0, discard the data (no writeback).
  - On transfer with an empty FIFO: discard and set err_o.
- Simultaneous push and pop: both apply and the count is unchanged. Pointers wrap modulo DEPTH.
- Results are returned in issue order. The coprocessor is in-order by protocol.
- Timeout:
  - Counter clears on any response transfer or when fifo_count==0; otherwise it increments.
  - When the counter reaches TIMEOUT_CYCLES-1, set err_o and flush the tag FIFO and request slot.
- Error:
  - While err_o==1, no commands are accepted, but responses are still acked and dropped.
  - err_clr_i clears err_o next cycle. If err_clr_i coincides with a new error event, the set wins.
- busy_o is registered-state derived: count≠0 or request slot full or wb slot full.

Test Plan:
- Single op: src0=0x12345678, src1=0, rd=5, coprocessor acks immediately and responds 2 cycles later with 0xDEADBEEF -> req_o high 1 cycle after cmd_ack_o; wb_req_o=1, wb_rd_o=5, wb_wdata_o=0xDEADBEEF one cycle after resp transfer; busy_o low after wb_ack_i.
- Back-pressure: hold ack_i low 5 cycles -> req_o stays high with stable payload, cmd_ack_o=0 for a second command until slot frees; hold wb_ack_i low -> resp ack_o=0, response not lost.
- Full FIFO with DEPTH=4: issue rd=1,2,3,4 with no responses -> 5th command not acked; return 0xA,0xB,0xC,0xD -> writebacks to rd 1..4 in order; push+pop in the same cycle keeps count.
- rd=0 command with response 0x55 -> resp acked, no wb_req_o, FIFO count decrements.
- Spurious response with nothing outstanding -> ack_o=1, err_o=1, cmd_ack_o blocked; err_clr_i pulse -> err_o=0 next cycle.
- Timeout with TIMEOUT_CYCLES=16: one outstanding, no response -> err_o=1 after 16 cycles, count=0. Also: rst_i low mid-flight clears all outputs next edge.
